// File: rtl/button_event_if.sv
// Debounced button level in, decoded single-cycle button events out.
// The decoder takes the slave view; the producer/observer of db takes the master view.
interface button_event_if;
  logic db;
  logic rise_tick;
  logic fall_tick;
  logic short_press;
  logic long_press;
  logic double_press;
  logic repeat_tick;
  logic long_active;

  modport master (
    output db,
    input  rise_tick, fall_tick, short_press, long_press,
           double_press, repeat_tick, long_active
  );

  modport slave (
    input  db,
    output rise_tick, fall_tick, short_press, long_press,
           double_press, repeat_tick, long_active
  );
endinterface

// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into edge, short/long/double press and
// auto-repeat pulses, timed by a private free-running 1 ms prescaler.
module button_event_decoder #(
  parameter int TICK_DIV  = 100_000,
  parameter int LONG_MS   = 1000,
  parameter int DBL_MS    = 300,
  parameter int REPEAT_MS = 200
) (
  input  logic         clk,
  input  logic         reset,
  button_event_if.slave bus
);

  localparam int MAX_AB = (LONG_MS > DBL_MS) ? LONG_MS : DBL_MS;
  localparam int MAX_MS = (MAX_AB > REPEAT_MS) ? MAX_AB : REPEAT_MS;
  localparam int CNT_W  = $clog2(MAX_MS) + 1;
  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_MS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_MS - 1);

  typedef enum logic [2:0] {IDLE, PRESS1, LONG_HELD, GAP, PRESS2} state_t;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] ms_cnt_q, ms_cnt_d;
  logic             db_q, db_d;
  logic             rise_tick_q, rise_tick_d;
  logic             fall_tick_q, fall_tick_d;
  logic             short_press_q, short_press_d;
  logic             long_press_q, long_press_d;
  logic             double_press_q, double_press_d;
  logic             repeat_tick_q, repeat_tick_d;
  logic             long_active_q, long_active_d;

  logic rise, fall, ms_tick, cnt_clr;

  always_comb begin
    rise    = bus.db & ~db_q;
    fall    = ~bus.db & db_q;
    ms_tick = (presc_q == PRE_LAST);
    presc_d = ms_tick ? '0 : presc_q + PRE_W'(1);
    db_d    = bus.db;

    state_d        = state_q;
    short_press_d  = 1'b0;
    long_press_d   = 1'b0;
    double_press_d = 1'b0;
    repeat_tick_d  = 1'b0;
    cnt_clr        = 1'b0;

    // Release/second-press edges are checked first so they win over timeouts.
    case (state_q)
      IDLE: begin
        if (rise) state_d = PRESS1;
      end
      PRESS1: begin
        if (fall) begin
          state_d = GAP;
        end else if (ms_tick && ms_cnt_q == LONG_LAST) begin
          state_d      = LONG_HELD;
          long_press_d = 1'b1;
        end
      end
      LONG_HELD: begin
        if (fall) begin
          state_d = IDLE;
        end else if (ms_tick && ms_cnt_q == REP_LAST) begin
          repeat_tick_d = 1'b1;
          cnt_clr       = 1'b1;
        end
      end
      GAP: begin
        if (rise) begin
          state_d        = PRESS2;
          double_press_d = 1'b1;
        end else if (ms_tick && ms_cnt_q == DBL_LAST) begin
          state_d       = IDLE;
          short_press_d = 1'b1;
        end
      end
      PRESS2: begin
        if (fall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q || cnt_clr) begin
      ms_cnt_d = '0;
    end else if (ms_tick && ms_cnt_q != '1) begin
      ms_cnt_d = ms_cnt_q + CNT_W'(1);
    end else begin
      ms_cnt_d = ms_cnt_q;
    end

    rise_tick_d   = rise;
    fall_tick_d   = fall;
    long_active_d = (state_d == LONG_HELD);
  end

  // db_q resets high so a button held through reset never reports a rise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      presc_q        <= '0;
      ms_cnt_q       <= '0;
      db_q           <= 1'b1;
      rise_tick_q    <= 1'b0;
      fall_tick_q    <= 1'b0;
      short_press_q  <= 1'b0;
      long_press_q   <= 1'b0;
      double_press_q <= 1'b0;
      repeat_tick_q  <= 1'b0;
      long_active_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      ms_cnt_q       <= ms_cnt_d;
      db_q           <= db_d;
      rise_tick_q    <= rise_tick_d;
      fall_tick_q    <= fall_tick_d;
      short_press_q  <= short_press_d;
      long_press_q   <= long_press_d;
      double_press_q <= double_press_d;
      repeat_tick_q  <= repeat_tick_d;
      long_active_q  <= long_active_d;
    end
  end

  assign bus.rise_tick    = rise_tick_q;
  assign bus.fall_tick    = fall_tick_q;
  assign bus.short_press  = short_press_q;
  assign bus.long_press   = long_press_q;
  assign bus.double_press = double_press_q;
  assign bus.repeat_tick  = repeat_tick_q;
  assign bus.long_active  = long_active_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with 1 ms = 4 clk; a negedge monitor
// counts and timestamps every event pulse, and directed steps check them.
module tb_button_event_decoder;

  localparam int TICK_DIV  = 4;
  localparam int LONG_MS   = 10;
  localparam int DBL_MS    = 5;
  localparam int REPEAT_MS = 3;

  logic clk;
  logic reset;

  button_event_if bus ();

  button_event_decoder #(
    .TICK_DIV (TICK_DIV),
    .LONG_MS  (LONG_MS),
    .DBL_MS   (DBL_MS),
    .REPEAT_MS(REPEAT_MS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  int ncyc = 0;
  int n0   = 0;
  int c_rise, c_fall, c_short, c_long, c_dbl, c_rep, c_multi;
  int t_rise, t_fall, t_short, t_long, t_dbl, t_rep_first, t_rep_last;

  // Sample pulses mid-cycle; ncyc numbers the cycle whose outputs are seen.
  always @(negedge clk) begin
    ncyc++;
    if (bus.rise_tick === 1'b1) begin c_rise++; t_rise = ncyc; end
    if (bus.fall_tick === 1'b1) begin c_fall++; t_fall = ncyc; end
    if (bus.short_press === 1'b1) begin c_short++; t_short = ncyc; end
    if (bus.long_press === 1'b1) begin c_long++; t_long = ncyc; end
    if (bus.double_press === 1'b1) begin c_dbl++; t_dbl = ncyc; end
    if (bus.repeat_tick === 1'b1) begin
      if (c_rep == 0) t_rep_first = ncyc;
      c_rep++;
      t_rep_last = ncyc;
    end
    if (int'(bus.short_press === 1'b1) + int'(bus.long_press === 1'b1) +
        int'(bus.double_press === 1'b1) > 1) c_multi++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v);
    bus.db = v;
  endtask

  task automatic clear_counts();
    c_rise = 0; c_fall = 0; c_short = 0; c_long = 0; c_dbl = 0; c_rep = 0;
    t_rise = -1; t_fall = -1; t_short = -1; t_long = -1; t_dbl = -1;
    t_rep_first = -1; t_rep_last = -1;
  endtask

  task automatic check_output(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    vectors++;
    assert (obs >= lo && obs <= hi) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_rise"},   int'(bus.rise_tick),    0);
    check_output({tag, "_fall"},   int'(bus.fall_tick),    0);
    check_output({tag, "_short"},  int'(bus.short_press),  0);
    check_output({tag, "_long"},   int'(bus.long_press),   0);
    check_output({tag, "_dbl"},    int'(bus.double_press), 0);
    check_output({tag, "_rep"},    int'(bus.repeat_tick),  0);
    check_output({tag, "_active"}, int'(bus.long_active),  0);
  endtask

  function automatic int phase(input int n);
    return (n - n0) % TICK_DIV;
  endfunction

  int d, f, r2, n_r, n1, n_t;

  initial begin
    clear_counts();
    c_multi = 0;
    reset = 1'b0;
    apply_stimulus(1'b0);
    tick(3);
    reset = 1'b1;
    n0 = ncyc + 1;
    check_all_zero("reset");
    tick(5);

    $display("[TB] short press");
    clear_counts();
    d = ncyc; apply_stimulus(1'b1); tick(20);
    f = ncyc; apply_stimulus(1'b0); tick(40);
    check_output("s1_rise_cnt", c_rise, 1);
    check_output("s1_rise_time", t_rise, d + 2);
    check_output("s1_fall_cnt", c_fall, 1);
    check_output("s1_fall_time", t_fall, f + 2);
    check_output("s1_short_cnt", c_short, 1);
    check_range("s1_short_lat", t_short - t_fall, 17, 20);
    check_output("s1_long_cnt", c_long, 0);
    check_output("s1_dbl_cnt", c_dbl, 0);

    $display("[TB] long press with repeat");
    clear_counts();
    d = ncyc; apply_stimulus(1'b1); tick(30);
    check_output("s2_active_early", int'(bus.long_active), 0);
    tick(20);
    check_output("s2_active_held", int'(bus.long_active), 1);
    tick(22);
    f = ncyc; apply_stimulus(1'b0); tick(3);
    check_output("s2_active_released", int'(bus.long_active), 0);
    tick(40);
    check_output("s2_long_cnt", c_long, 1);
    check_range("s2_long_lat", t_long - d, 39, 42);
    check_output("s2_rep_cnt", c_rep, 2);
    check_output("s2_rep_first", t_rep_first - t_long, 12);
    check_output("s2_rep_period", t_rep_last - t_rep_first, 12);
    check_output("s2_fall_time", t_fall, f + 2);
    check_output("s2_short_cnt", c_short, 0);
    check_output("s2_dbl_cnt", c_dbl, 0);

    $display("[TB] double press");
    clear_counts();
    apply_stimulus(1'b1); tick(8);
    apply_stimulus(1'b0); tick(8);
    r2 = ncyc; apply_stimulus(1'b1); tick(8);
    apply_stimulus(1'b0); tick(40);
    check_output("s3_dbl_cnt", c_dbl, 1);
    check_output("s3_dbl_time", t_dbl, r2 + 2);
    check_output("s3_rise_cnt", c_rise, 2);
    check_output("s3_fall_cnt", c_fall, 2);
    check_output("s3_short_cnt", c_short, 0);
    check_output("s3_long_cnt", c_long, 0);

    $display("[TB] release on long threshold");
    clear_counts();
    d = ncyc; apply_stimulus(1'b1);
    n_r = d + 2;
    n1  = n_r + ((TICK_DIV - 1 - phase(n_r)) % TICK_DIV);
    n_t = n1 + (LONG_MS - 1) * TICK_DIV;
    while (ncyc < n_t - 1) tick(1);
    apply_stimulus(1'b0); tick(40);
    check_output("s4_long_cnt", c_long, 0);
    check_output("s4_fall_time", t_fall, n_t + 1);
    check_output("s4_short_cnt", c_short, 1);
    check_output("s4_short_time", t_short, n_t + 21);

    $display("[TB] release one cycle after long threshold");
    clear_counts();
    d = ncyc; apply_stimulus(1'b1);
    n_r = d + 2;
    n1  = n_r + ((TICK_DIV - 1 - phase(n_r)) % TICK_DIV);
    n_t = n1 + (LONG_MS - 1) * TICK_DIV;
    while (ncyc < n_t) tick(1);
    apply_stimulus(1'b0); tick(40);
    check_output("s4b_long_cnt", c_long, 1);
    check_output("s4b_long_time", t_long, n_t + 1);
    check_output("s4b_fall_time", t_fall, n_t + 2);
    check_output("s4b_short_cnt", c_short, 0);
    check_output("s4b_rep_cnt", c_rep, 0);

    $display("[TB] button held through reset");
    clear_counts();
    apply_stimulus(1'b1);
    reset = 1'b0; tick(2);
    reset = 1'b1; n0 = ncyc + 1;
    tick(10);
    check_output("s5_rise_cnt", c_rise, 0);
    f = ncyc; apply_stimulus(1'b0); tick(40);
    check_output("s5_fall_cnt", c_fall, 1);
    check_output("s5_fall_time", t_fall, f + 2);
    check_output("s5_short_cnt", c_short, 0);
    check_output("s5_long_cnt", c_long, 0);
    check_output("s5_dbl_cnt", c_dbl, 0);

    $display("[TB] reset mid press");
    clear_counts();
    apply_stimulus(1'b1); tick(12);
    reset = 1'b0; tick(1);
    check_all_zero("s6_mid_press1");
    reset = 1'b1; n0 = ncyc + 1;
    tick(60);
    check_output("s6_long_cnt", c_long, 0);
    check_output("s6_rise_cnt", c_rise, 1);
    check_output("s6_active", int'(bus.long_active), 0);
    apply_stimulus(1'b0); tick(40);
    check_output("s6_fall_cnt", c_fall, 1);
    check_output("s6_short_cnt", c_short, 0);

    $display("[TB] reset during long hold");
    clear_counts();
    apply_stimulus(1'b1); tick(50);
    check_output("s7_active_before", int'(bus.long_active), 1);
    reset = 1'b0; tick(1);
    check_output("s7_active_after", int'(bus.long_active), 0);
    reset = 1'b1; n0 = ncyc + 1;
    tick(20);
    apply_stimulus(1'b0); tick(40);
    check_output("s7_long_cnt", c_long, 1);
    check_output("s7_fall_cnt", c_fall, 1);
    check_output("s7_short_cnt", c_short, 0);

    check_output("one_hot_events", c_multi, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Downstream consumer of the debounced switch level `db`.
- Produces single-cycle event pulses for the rest of the design:
  - rising and falling edges;
  - short press, long press and double press;
  - auto-repeat while a long press is held.
- Contains its own free-running 1 ms tick prescaler, so press timing is independent of the debouncer's tick.

Parameters:
- TICK_DIV, 100_000: clk cycles per 1 ms tick (100 MHz clk).
- LONG_MS, 1000: hold time in ms that classifies a press as long.
- DBL_MS, 300: maximum release-to-second-press gap in ms for a double press.
- REPEAT_MS, 200: repeat_tick period in ms while a long press is held.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: synchronous, active-low reset (asserted when 0).
- db, input, 1: debounced switch level, already synchronous to clk.
- rise_tick, output, 1: one-cycle pulse on a db 0->1 edge.
- fall_tick, output, 1: one-cycle pulse on a db 1->0 edge.
- short_press, output, 1: one-cycle pulse; a single short press has completed.
- long_press, output, 1: one-cycle pulse; the hold reached LONG_MS.
- double_press, output, 1: one-cycle pulse; a second press started within DBL_MS of release.
- repeat_tick, output, 1: one-cycle pulse every REPEAT_MS while in LONG_HELD.
- long_active, output, 1: level, high while in LONG_HELD.

Behaviour:
- Reset:
  - Sampled only at the posedge clk where reset==0.
  - All outputs go to 0 and state goes to IDLE.
  - Prescaler and ms counter clear to 0.
  - db_q loads 1, so a button held through reset produces no rise_tick. Its later release gives fall_tick only.
  - Reset mid-press abandons the press silently.
- Edge detect:
  - db_q <= db every cycle; rise = db & ~db_q; fall = ~db & db_q.
  - rise_tick/fall_tick are registered: high for exactly the one cycle after the first edge at which the new db level is sampled.
  - These pulses are generated in every state.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - ms_tick is high in the cycle where count==TICK_DIV-1.
  - Free-running; cleared only by reset.
- ms counter:
  - Width clog2(max(LONG_MS,DBL_MS,REPEAT_MS))+1.
  - Cleared to 0 on every state transition; otherwise +1 on ms_tick.
  - Saturates at all-ones.
  - Timing resolution is ±1 ms: a threshold of N fires between N-1 and N ms after state entry.
- FSM states: IDLE, PRESS1, LONG_HELD, GAP, PRESS2.
  - IDLE:
    - rise -> PRESS1.
    - fall is ignored.
  - PRESS1:
    - fall -> GAP.
    - else (ms_tick && ms_cnt==LONG_MS-1) -> LONG_HELD, pulse long_press.
  - LONG_HELD:
    - long_active=1.
    - Each time (ms_tick && ms_cnt==REPEAT_MS-1): pulse repeat_tick and clear ms_cnt.
    - fall -> IDLE (no short_press).
  - GAP:
    - rise -> PRESS2, pulse double_press.
    - else (ms_tick && ms_cnt==DBL_MS-1) -> IDLE, pulse short_press.
  - PRESS2:
    - fall -> IDLE.
    - No further events; no long classification.
- Event pulses:
  - Registered; high in the cycle after the transition edge (same latency as rise_tick).
  - At most one of short_press/long_press/double_press is high in any cycle.
- Simultaneous events:
  - PRESS1: fall wins over the long threshold (-> GAP, no long_press).
  - GAP: rise wins over the timeout (double_press, no short_press).
  - LONG_HELD: fall wins over repeat (no repeat_tick).
- short_press latency after release is inherent: DBL_MS-1..DBL_MS ms.

Test Plan (TICK_DIV=4, LONG_MS=10, DBL_MS=5, REPEAT_MS=3, 1 ms = 4 clk):
- db high for 20 clk, then low for 40 clk:
  - rise_tick one cycle after db sampled high; fall_tick one cycle after db sampled low.
  - short_press once, 16..20 clk after release.
  - No long_press or double_press.
- db high for 60 clk:
  - long_press once, 36..40 clk after rise; long_active=1 from then on.
  - repeat_tick every 12 clk.
  - On release: long_active=0, fall_tick, and no short_press.
- Press 8 clk, release 8 clk, press again:
  - double_press one cycle after the second rise is registered.
  - No short_press.
  - Releasing the second press returns to IDLE with no further events.
- Construct db fall in the same cycle as the PRESS1 long threshold (ms_tick with ms_cnt==9):
  - No long_press; FSM enters GAP; short_press follows after timeout.
- db held high across reset deassertion, then released:
  - No rise_tick; one fall_tick; no press events.
  - reset=0 applied mid-PRESS1: all outputs 0 on the next cycle and no later events.
